// File: rtl/be_mem_pkg.sv
// Shared types and constants for the cache back-end to SRAM controller.
package be_mem_pkg;

  localparam int          WAIT_CNT_W = 4;
  localparam logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Byte-address bits that lie above the SRAM window for a given word-address width.
  function automatic logic [31:0] addr_hi_mask(input int unsigned aw);
    if (aw + 2 >= 32) begin
      addr_hi_mask = 32'd0;
    end else begin
      addr_hi_mask = ~((32'd1 << (aw + 2)) - 32'd1);
    end
  endfunction

endpackage

// File: rtl/be_wait_cnt.sv
// Loadable down-counter that paces the wait states ahead of each SRAM access.
module be_wait_cnt
  import be_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_load,
  input  logic [WAIT_CNT_W-1:0] i_load_val,
  input  logic                  i_dec,
  output logic [WAIT_CNT_W-1:0] o_cnt,
  output logic                  o_zero
);

  logic [WAIT_CNT_W-1:0] r_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WAIT_CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/be_mem_ctrl.sv
// Cache back-end to single-port SRAM controller with programmable wait states.
// Define BE_MEM_ERR_EN to flag out-of-range addresses instead of aliasing them.
module be_mem_ctrl
  import be_mem_pkg::*;
#(
  parameter int MEM_ADDR_W = 12,
  parameter int WAIT_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  be_valid_i,
  input  logic [31:0]           be_addr_i,
  input  logic [31:0]           be_wdata_i,
  input  logic [3:0]            be_wstrb_i,
  output logic                  be_ready_o,
  output logic                  be_rvalid_o,
  output logic [31:0]           be_rdata_o,
  output logic                  mem_en_o,
  output logic [3:0]            mem_we_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  output logic                  err_o
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYC);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [MEM_ADDR_W-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;

  logic                  w_accept;
  logic                  w_mem_ok;
  logic [31:0]           w_rdata_resp;
  logic [WAIT_CNT_W-1:0] w_cnt;
  logic                  w_cnt_zero;
  logic                  w_unused;

  assign w_accept = (r_state == ST_IDLE) && be_valid_i;

  // Byte-lane bits and, when aliasing, the upper address bits never select a word.
  assign w_unused = &{1'b0, be_addr_i};

  be_wait_cnt u_wait_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_accept),
    .i_load_val (WAIT_LOAD),
    .i_dec      (r_state == ST_WAIT),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (w_accept) begin
      r_addr  <= be_addr_i[MEM_ADDR_W+1:2];
      r_wdata <= be_wdata_i;
      r_wstrb <= be_wstrb_i;
    end
  end

`ifdef BE_MEM_ERR_EN
  localparam logic [31:0] HI_MASK = addr_hi_mask(MEM_ADDR_W);

  logic r_oor;
  logic r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_oor <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_oor <= |(be_addr_i & HI_MASK);
      end
      if ((r_state == ST_ACCESS) && r_oor) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_mem_ok     = ~r_oor;
  assign w_rdata_resp = r_oor ? ERR_RDATA : mem_rdata_i;
  assign err_o        = r_err;
`else
  assign w_mem_ok     = 1'b1;
  assign w_rdata_resp = mem_rdata_i;
  assign err_o        = 1'b0;
`endif

  // NOTE: every output and the next state get a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    be_ready_o  = 1'b0;
    be_rvalid_o = 1'b0;
    be_rdata_o  = '0;
    mem_en_o    = 1'b0;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    case (r_state)
      ST_IDLE: begin
        if (be_valid_i) begin
          w_state_nxt = (WAIT_CYC == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_cnt_zero || (w_cnt == WAIT_CNT_W'(1))) begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        be_ready_o = 1'b1;
        if (w_mem_ok) begin
          mem_en_o    = 1'b1;
          mem_we_o    = r_wstrb;
          mem_addr_o  = r_addr;
          mem_wdata_o = r_wdata;
        end
        w_state_nxt = (r_wstrb != 4'b0000) ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        be_rvalid_o = 1'b1;
        be_rdata_o  = w_rdata_resp;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_be_mem_ctrl.sv
// Directed bench for be_mem_ctrl: one instance with two wait states (A), one with none (B).
module tb_be_mem_ctrl;

  localparam int AW = 12;

  typedef struct {
    int              rdy_cyc;
    int              rdy_cnt;
    int              rv_cyc;
    int              rv_cnt;
    logic [31:0]     rv_data;
    logic [AW-1:0]   m_addr;
    logic [3:0]      m_we;
    logic [31:0]     m_wdata;
    int              en_cnt;
    int              leak;
  } res_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          a_valid, a_ready, a_rvalid, a_en, a_err;
  logic [31:0]   a_addr, a_wdata, a_rdata, a_mwdata, a_mrdata;
  logic [3:0]    a_wstrb, a_we;
  logic [AW-1:0] a_maddr;
  logic          b_valid, b_ready, b_rvalid, b_en, b_err;
  logic [31:0]   b_addr, b_wdata, b_rdata, b_mwdata, b_mrdata;
  logic [3:0]    b_wstrb, b_we;
  logic [AW-1:0] b_maddr;

  logic [31:0] sram_a [4096];
  logic [31:0] sram_b [4096];

  int n_tests = 0;
  int n_fail  = 0;
  int rdy_k[$];
  int rv_k[$];
  logic [31:0] rv_d[$];
  int quiet_cnt;
  res_t r;

  be_mem_ctrl #(.MEM_ADDR_W(AW), .WAIT_CYC(2)) u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .be_valid_i(a_valid), .be_addr_i(a_addr), .be_wdata_i(a_wdata), .be_wstrb_i(a_wstrb),
    .be_ready_o(a_ready), .be_rvalid_o(a_rvalid), .be_rdata_o(a_rdata),
    .mem_en_o(a_en), .mem_we_o(a_we), .mem_addr_o(a_maddr), .mem_wdata_o(a_mwdata),
    .mem_rdata_i(a_mrdata), .err_o(a_err)
  );

  be_mem_ctrl #(.MEM_ADDR_W(AW), .WAIT_CYC(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .be_valid_i(b_valid), .be_addr_i(b_addr), .be_wdata_i(b_wdata), .be_wstrb_i(b_wstrb),
    .be_ready_o(b_ready), .be_rvalid_o(b_rvalid), .be_rdata_o(b_rdata),
    .mem_en_o(b_en), .mem_we_o(b_we), .mem_addr_o(b_maddr), .mem_wdata_o(b_mwdata),
    .mem_rdata_i(b_mrdata), .err_o(b_err)
  );

  // Synchronous SRAM models: read data appears the cycle after a read enable.
  always @(posedge clk) begin
    if (a_en) begin
      if (a_we == 4'b0000) a_mrdata <= sram_a[a_maddr];
      else for (int i = 0; i < 4; i++) if (a_we[i]) sram_a[a_maddr][8*i +: 8] <= a_mwdata[8*i +: 8];
    end
  end

  always @(posedge clk) begin
    if (b_en) begin
      if (b_we == 4'b0000) b_mrdata <= sram_b[b_maddr];
      else for (int i = 0; i < 4; i++) if (b_we[i]) sram_b[b_maddr][8*i +: 8] <= b_mwdata[8*i +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int idx);
    return (q.size() > idx) ? q[idx] : -1;
  endfunction

  task automatic check_quiet_a(input string tag);
    check({tag, "_ctl"}, 32'({a_ready, a_rvalid, a_en, a_err, a_we}), 32'd0);
    check({tag, "_data"}, a_rdata | a_mwdata | 32'(a_maddr), 32'd0);
  endtask

  // Issue one request, hold valid until ready, and record what happens over 10 cycles.
  // Cycle k is observed on the falling edge after the k-th rising edge from acceptance.
  task automatic do_req(input bit sel_b, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output res_t res);
    logic rdy, rv, en;
    logic [31:0] rd;
    res = '{default: 0};
    res.rdy_cyc = -1;
    res.rv_cyc  = -1;
    @(negedge clk);
    if (sel_b) begin b_valid = 1'b1; b_addr = addr; b_wdata = wdata; b_wstrb = wstrb; end
    else       begin a_valid = 1'b1; a_addr = addr; a_wdata = wdata; a_wstrb = wstrb; end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      rdy = sel_b ? b_ready  : a_ready;
      rv  = sel_b ? b_rvalid : a_rvalid;
      en  = sel_b ? b_en     : a_en;
      rd  = sel_b ? b_rdata  : a_rdata;
      if (en) res.en_cnt++;
      if (rdy) begin
        res.rdy_cnt++;
        if (res.rdy_cyc < 0) begin
          res.rdy_cyc = k;
          res.m_addr  = sel_b ? b_maddr  : a_maddr;
          res.m_we    = sel_b ? b_we     : a_we;
          res.m_wdata = sel_b ? b_mwdata : a_mwdata;
        end
        if (sel_b) b_valid = 1'b0; else a_valid = 1'b0;
      end
      if (rv) begin
        res.rv_cnt++;
        if (res.rv_cyc < 0) begin
          res.rv_cyc  = k;
          res.rv_data = rd;
        end
      end else if (rd !== 32'd0) begin
        res.leak++;
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
    b_valid = 1'b0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
    repeat (2) @(negedge clk);
    check_quiet_a("reset_a");
    check("reset_b_ctl", 32'({b_ready, b_rvalid, b_en, b_err, b_we}), 32'd0);
    reset_n = 1'b1;

    // Full-word write with two wait states.
    do_req(1'b0, 32'h0000_0010, 32'h1234_5678, 4'hF, r);
    check("wr_ready_cyc", r.rdy_cyc, 3);
    check("wr_ready_cnt", r.rdy_cnt, 1);
    check("wr_mem_addr", 32'(r.m_addr), 32'd4);
    check("wr_mem_we", 32'(r.m_we), 32'hF);
    check("wr_mem_wdata", r.m_wdata, 32'h1234_5678);
    check("wr_en_cnt", r.en_cnt, 1);
    check("wr_no_rvalid", r.rv_cnt, 0);

    // Read it back.
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, r);
    check("rd_ready_cyc", r.rdy_cyc, 3);
    check("rd_rvalid_cyc", r.rv_cyc, 4);
    check("rd_rvalid_cnt", r.rv_cnt, 1);
    check("rd_data", r.rv_data, 32'h1234_5678);
    check("rd_mem_we", 32'(r.m_we), 32'h0);
    check("rd_rdata_idle_zero", r.leak, 0);

    // Zero wait states with a partial-strobe write.
    do_req(1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, r);
    check("w0_full_ready_cyc", r.rdy_cyc, 1);
    do_req(1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'b0010, r);
    check("w0_part_ready_cyc", r.rdy_cyc, 1);
    check("w0_part_mem_we", 32'(r.m_we), 32'h2);
    do_req(1'b1, 32'h0000_0010, 32'h0, 4'h0, r);
    check("w0_rd_ready_cyc", r.rdy_cyc, 1);
    check("w0_rd_rvalid_cyc", r.rv_cyc, 2);
    check("w0_rd_data", r.rv_data, 32'h1234_CC78);

    // Preload words used by the aliasing and back-to-back steps.
    do_req(1'b0, 32'h0000_0004, 32'h1111_0001, 4'hF, r);
    do_req(1'b0, 32'h0000_0008, 32'h2222_0002, 4'hF, r);
    do_req(1'b0, 32'h0000_0000, 32'hCAFE_0000, 4'hF, r);
    check("err_clear", 32'(a_err), 32'd0);

    // Address above the SRAM window.
    do_req(1'b0, 32'h0001_0000, 32'h0, 4'h0, r);
    check("oor_ready_cyc", r.rdy_cyc, 3);
    check("oor_rvalid_cyc", r.rv_cyc, 4);
`ifdef BE_MEM_ERR_EN
    check("oor_en_cnt", r.en_cnt, 0);
    check("oor_rdata", r.rv_data, 32'hDEAD_BEEF);
    check("oor_err", 32'(a_err), 32'd1);
    do_req(1'b0, 32'h0000_0004, 32'h0, 4'h0, r);
    check("oor_next_rdata", r.rv_data, 32'h1111_0001);
    check("oor_err_sticky", 32'(a_err), 32'd1);
`else
    check("alias_en_cnt", r.en_cnt, 1);
    check("alias_mem_addr", 32'(r.m_addr), 32'd0);
    check("alias_rdata", r.rv_data, 32'hCAFE_0000);
    check("alias_err", 32'(a_err), 32'd0);
`endif

    // Valid held across two back-to-back reads.
    @(negedge clk);
    a_valid = 1'b1; a_addr = 32'h0000_0004; a_wstrb = 4'h0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (a_ready) begin
        rdy_k.push_back(k);
        if (rdy_k.size() == 1) a_addr = 32'h0000_0008;
        else a_valid = 1'b0;
      end
      if (a_rvalid) begin
        rv_k.push_back(k);
        rv_d.push_back(a_rdata);
      end
    end
    a_valid = 1'b0;
    check("b2b_ready_cnt", rdy_k.size(), 2);
    check("b2b_rvalid_cnt", rv_k.size(), 2);
    check("b2b_ready0_cyc", qget(rdy_k, 0), 3);
    check("b2b_rvalid0_cyc", qget(rv_k, 0), 4);
    check("b2b_ready1_cyc", qget(rdy_k, 1), 8);
    check("b2b_rvalid1_cyc", qget(rv_k, 1), 9);
    check("b2b_data0", (rv_d.size() > 0) ? rv_d[0] : 32'hFFFF_FFFF, 32'h1111_0001);
    check("b2b_data1", (rv_d.size() > 1) ? rv_d[1] : 32'hFFFF_FFFF, 32'h2222_0002);

    // Reset while a read is waiting.
    @(negedge clk);
    a_valid = 1'b1; a_addr = 32'h0000_0010; a_wstrb = 4'h0;
    @(negedge clk);
    a_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_quiet_a("rst_wait");
    @(negedge clk);
    reset_n = 1'b1;
    quiet_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_ready || a_rvalid) quiet_cnt++;
    end
    check("rst_wait_no_pulse", quiet_cnt, 0);

    // Reset in the middle of a write access.
    @(negedge clk);
    a_valid = 1'b1; a_addr = 32'h0000_0020; a_wdata = 32'h5555_AAAA; a_wstrb = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_acc_pre_en", 32'({a_en, a_ready}), 32'd3);
    a_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_quiet_a("rst_acc");
    @(negedge clk);
    reset_n = 1'b1;
    quiet_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_ready || a_rvalid || a_en) quiet_cnt++;
    end
    check("rst_acc_no_pulse", quiet_cnt, 0);

    // Controller still works after reset.
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, r);
    check("post_rst_rdata", r.rv_data, 32'h1234_5678);
    check("post_rst_rvalid_cyc", r.rv_cyc, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/be_mem_ctrl.md
BE_MEM_CTRL -- requirements
Module: be_mem_ctrl

Interface
REQ-001 Parameter MEM_ADDR_W, default 12: word-address width of the attached SRAM (4096 words).
REQ-002 Parameter WAIT_CYC, default 2: wait states inserted before each SRAM access, range 0..15.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 be_valid_i  input  1  cache back-end request valid, held until be_ready_o.
REQ-006 be_addr_i  input  32  byte address; bits [1:0] ignored.
REQ-007 be_wdata_i  input  32  write data.
REQ-008 be_wstrb_i  input  4  byte write strobes; 4'b0000 = read.
REQ-009 be_ready_o  output  1  one-cycle pulse: request completed/accepted.
REQ-010 be_rvalid_o  output  1  one-cycle pulse: be_rdata_o valid.
REQ-011 be_rdata_o  output  32  read data, 0 when be_rvalid_o low.
REQ-012 mem_en_o  output  1  SRAM enable.
REQ-013 mem_we_o  output  4  SRAM byte write enables.
REQ-014 mem_addr_o  output  MEM_ADDR_W  SRAM word address.
REQ-015 mem_wdata_o  output  32  SRAM write data.
REQ-016 mem_rdata_i  input  32  SRAM read data, valid one cycle after a read enable.
REQ-017 err_o  output  1  sticky out-of-range flag.

Function
REQ-018 FSM states IDLE, WAIT, ACCESS, RESP; binary-encoded.
REQ-019 IDLE: on be_valid_i=1, latch addr/wdata/wstrb, load wait counter with WAIT_CYC; go to WAIT if WAIT_CYC>0, else ACCESS.
REQ-020 WAIT: decrement counter each cycle; go to ACCESS in the cycle after it reaches 1.
REQ-021 ACCESS: drive mem_en_o=1, mem_addr_o=latched addr[MEM_ADDR_W+1:2], mem_we_o=latched wstrb, mem_wdata_o=latched wdata, and be_ready_o=1, all for exactly one cycle.
REQ-022 ACCESS transitions to IDLE for writes (wstrb!=0) and to RESP for reads.
REQ-023 RESP: be_rvalid_o=1, be_rdata_o=mem_rdata_i for one cycle, then IDLE.
REQ-024 Latency from be_valid_i sampled in IDLE: be_ready_o at cycle 1+WAIT_CYC; read be_rvalid_o at cycle 2+WAIT_CYC.
REQ-025 be_valid_i is ignored outside IDLE; a request still asserted on return to IDLE is treated as a new request.
REQ-026 Memory outputs are 0 in all states except ACCESS.
REQ-027 Partial strobes pass through unchanged to mem_we_o.

Reset
REQ-028 reset_n low immediately forces IDLE, counter 0, latched request cleared, err_o 0, all outputs 0.
REQ-029 Reset during WAIT/ACCESS/RESP drops the pending request with no ready/rvalid pulse after release.

Configuration
REQ-030 With BE_MEM_ERR_EN defined: a request with any be_addr_i bit above MEM_ADDR_W+1 set is out of range; ACCESS still pulses be_ready_o but holds mem_en_o=0; a read returns be_rdata_o=32'hDEAD_BEEF in RESP; err_o sets and remains 1 until reset.
REQ-031 Without BE_MEM_ERR_EN: upper address bits are ignored (aliasing), every request accesses SRAM, err_o tied 0.

Structure
REQ-032 Package be_mem_pkg holds state enum, ERR_RDATA (32'hDEAD_BEEF) and wait-counter width (4).
REQ-033 One sub-module be_wait_cnt: loadable down-counter with zero flag; FSM in top.

Verification
REQ-034 WAIT_CYC=2; write addr 0x0000_0010, data 0x1234_5678, wstrb 4'hF -> be_ready_o at cycle 3, mem_addr_o=4, mem_we_o=4'hF, no be_rvalid_o.
REQ-035 Read back 0x10 -> be_ready_o at cycle 3, be_rvalid_o at cycle 4 with be_rdata_o=0x1234_5678.
REQ-036 WAIT_CYC=0; write wstrb 4'b0010 data 0xAABB_CCDD to 0x10, then read -> ready at cycle 1, rvalid at cycle 2, data 0x1234_CC78.
REQ-037 BE_MEM_ERR_EN, read 0x0001_0000 -> mem_en_o never 1, be_rdata_o=0xDEAD_BEEF, err_o=1 sticky; undefined macro -> reads SRAM word 0, err_o=0.
REQ-038 reset_n low in WAIT of a read -> outputs 0 immediately; after release with be_valid_i=0 no be_ready_o/be_rvalid_o for 10 cycles.
REQ-039 be_valid_i held high across two back-to-back reads (0x4, 0x8) -> two ready/rvalid pairs, second request accepted in the IDLE cycle after the first RESP.
